// File: rtl/core_run_ctrl_pkg.sv
// core_run_ctrl_pkg
//   Shared definitions for the run-control sequencer: the existing
//   EXCEPTION_NUM / PC_WIDTH defines, done-code and core-status encodings,
//   and the sequencer FSM state type.
`ifndef EXCEPTION_NUM
`define EXCEPTION_NUM 8
`endif
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif

package core_run_ctrl_pkg;

  localparam int EXCEPTION_NUM = `EXCEPTION_NUM;
  localparam int PC_WIDTH      = `PC_WIDTH;

  // Completion codes returned to the SoC
  localparam logic [1:0] DONE_WFI = 2'b00;
  localparam logic [1:0] DONE_EXC = 2'b01;
  localparam logic [1:0] DONE_TMO = 2'b10;
  localparam logic [1:0] DONE_ABT = 2'b11;

  // Core status register encodings (2'b11 = illegal)
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_WFI  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_ARM  = 2'b01,
    S_RUN  = 2'b10,
    S_DONE = 2'b11
  } run_state_t;

endpackage

// File: rtl/core_run_ctrl_if.sv
// core_run_ctrl_if
//   SoC-side bundle of the run-control sequencer: start request channel
//   (req/ack + cfg/limit), software abort and the completion record channel.
//   master: SoC side, slave: core_run_ctrl.
//
//   Handshake rule for both channels: a transfer happens on a rising clk
//   edge where valid (soc_start_req / done_vld) and ready (soc_start_ack /
//   done_rdy) are both high; a valid source holds its payload stable until
//   that edge, and ready without valid has no effect.
interface core_run_ctrl_if #(
  parameter int CNT_W = 32
);
  import core_run_ctrl_pkg::*;

  logic                     soc_start_req;
  logic                     soc_start_ack;
  logic [EXCEPTION_NUM-1:0] soc_start_cfg;
  logic [CNT_W-1:0]         soc_timeout_limit;
  logic                     soc_abort;

  logic                     done_vld;
  logic                     done_rdy;
  logic [1:0]               done_code;
  logic [EXCEPTION_NUM-1:0] done_exceptions;
  logic [PC_WIDTH-1:0]      done_pc;
  logic [CNT_W-1:0]         done_cycles;

  modport master (
    output soc_start_req, soc_start_cfg, soc_timeout_limit, soc_abort, done_rdy,
    input  soc_start_ack, done_vld, done_code, done_exceptions, done_pc, done_cycles
  );

  modport slave (
    input  soc_start_req, soc_start_cfg, soc_timeout_limit, soc_abort, done_rdy,
    output soc_start_ack, done_vld, done_code, done_exceptions, done_pc, done_cycles
  );

endinterface

// File: rtl/core_run_ctrl_counter.sv
// run_cycle_counter
//   Saturating run-cycle counter.
//   clk, rst_n   : clock, async active-low reset
//   clr          : synchronous clear (has priority over en)
//   en           : increment by one, sticking at all-ones
//   limit        : watchdog limit, 0 = disabled
//   cnt          : current count
//   cnt_inc      : cnt + 1, saturating (value the count would take next)
//   limit_hit    : limit != 0 and cnt == limit - 1
module run_cycle_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_inc,
  output logic             limit_hit
);

  assign cnt_inc   = (&cnt) ? cnt : cnt + CNT_W'(1);
  assign limit_hit = (limit != '0) && (cnt == limit - CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt_inc;
    end
  end

endmodule

// File: rtl/core_run_ctrl.sv
// core_run_ctrl
//   Run-control sequencer between the SoC and the core status register.
//   Accepts a start (cfg + watchdog limit), emits a one-cycle start pulse,
//   watches the core until it stops / times out / is aborted, and returns a
//   completion record.
//   clk, rst_n              : clock, async active-low reset
//   soc                     : SoC bundle (start channel, abort, done channel)
//   sync_start_pulse        : one-cycle start strobe (ARM state)
//   sync_core_configuration : cfg latched at start accept
//   core_status             : 00 idle/exc, 01 running, 10 WFI, 11 illegal
//   core_exceptions(_pc)    : exception vector / PC from the status register
//   busy                    : state is not IDLE
//   state_dbg               : current FSM state
module core_run_ctrl
  import core_run_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  core_run_ctrl_if.slave           soc,
  output logic                     sync_start_pulse,
  output logic [EXCEPTION_NUM-1:0] sync_core_configuration,
  input  logic [1:0]               core_status,
  input  logic [EXCEPTION_NUM-1:0] core_exceptions,
  input  logic [PC_WIDTH-1:0]      core_exceptions_pc,
  output logic                     busy,
  output run_state_t               state_dbg
);

  run_state_t       state_q, state_d;
  logic             accept;
  logic             capture;
  logic [1:0]       code_d;
  logic             cnt_en;
  logic [CNT_W-1:0] limit_q;
  logic [CNT_W-1:0] run_cnt;
  logic [CNT_W-1:0] run_cnt_inc;
  logic             tmo_hit;

  run_cycle_counter #(
    .CNT_W (CNT_W)
  ) u_run_cycle_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (accept),
    .en        (cnt_en),
    .limit     (limit_q),
    .cnt       (run_cnt),
    .cnt_inc   (run_cnt_inc),
    .limit_hit (tmo_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Exit priority in RUN: status change, then timeout, then abort.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    code_d  = DONE_WFI;
    cnt_en  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (soc.soc_start_req) begin
          accept  = 1'b1;
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        if (core_status != ST_RUN) begin
          capture = 1'b1;
          code_d  = (core_status == ST_WFI) ? DONE_WFI : DONE_EXC;
          state_d = S_DONE;
        end else if (tmo_hit) begin
          capture = 1'b1;
          code_d  = DONE_TMO;
          state_d = S_DONE;
        end else if (soc.soc_abort) begin
          capture = 1'b1;
          code_d  = DONE_ABT;
          state_d = S_DONE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      S_DONE: begin
        if (soc.done_rdy) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign soc.soc_start_ack = (state_q == S_IDLE);
  assign soc.done_vld      = (state_q == S_DONE);
  assign sync_start_pulse  = (state_q == S_ARM);
  assign busy              = (state_q != S_IDLE);
  assign state_dbg         = state_q;

  // Start configuration: held from accept until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_core_configuration <= '0;
      limit_q                 <= '0;
    end else if (accept) begin
      sync_core_configuration <= soc.soc_start_cfg;
      limit_q                 <= soc.soc_timeout_limit;
    end
  end

  // Completion record: held from one RUN exit until the next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      soc.done_code       <= DONE_WFI;
      soc.done_exceptions <= '0;
      soc.done_pc         <= '0;
      soc.done_cycles     <= '0;
    end else if (capture) begin
      soc.done_code       <= code_d;
      soc.done_exceptions <= core_exceptions;
      soc.done_pc         <= core_exceptions_pc;
      soc.done_cycles     <= run_cnt_inc;
    end
  end

endmodule

// File: tb/tb_core_run_ctrl.sv
// tb_core_run_ctrl
//   Directed bench for core_run_ctrl. The DUT counter is narrowed to 4 bits
//   so saturation and the largest timeout are reachable quickly.
module tb_core_run_ctrl;
  import core_run_ctrl_pkg::*;

  localparam int CNT_W = 4;
  localparam int REC_W = 2 + EXCEPTION_NUM + PC_WIDTH + CNT_W;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUT ----------------
  core_run_ctrl_if #(.CNT_W(CNT_W)) bus ();

  logic                     sync_start_pulse;
  logic [EXCEPTION_NUM-1:0] sync_core_configuration;
  logic [1:0]               core_status;
  logic [EXCEPTION_NUM-1:0] core_exceptions;
  logic [PC_WIDTH-1:0]      core_exceptions_pc;
  logic                     busy;
  run_state_t               state_dbg;

  core_run_ctrl #(.CNT_W(CNT_W)) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .soc                     (bus.slave),
    .sync_start_pulse        (sync_start_pulse),
    .sync_core_configuration (sync_core_configuration),
    .core_status             (core_status),
    .core_exceptions         (core_exceptions),
    .core_exceptions_pc      (core_exceptions_pc),
    .busy                    (busy),
    .state_dbg               (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int pulse_cnt = 0;
  logic [REC_W-1:0] exp_q[$];

  always @(negedge clk) if (sync_start_pulse) pulse_cnt++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_done(input logic [1:0] code, input logic [EXCEPTION_NUM-1:0] exc,
                             input logic [PC_WIDTH-1:0] pc, input logic [CNT_W-1:0] cyc);
    exp_q.push_back({code, exc, pc, cyc});
  endtask

  task automatic check_done(input string tag);
    logic [REC_W-1:0] e;
    e = exp_q.pop_front();
    check({tag, "_vld"},  64'(bus.done_vld), 64'd1);
    check({tag, "_code"}, 64'(bus.done_code), 64'(e[REC_W-1 -: 2]));
    check({tag, "_exc"},  64'(bus.done_exceptions), 64'(e[PC_WIDTH+CNT_W +: EXCEPTION_NUM]));
    check({tag, "_pc"},   64'(bus.done_pc), 64'(e[CNT_W +: PC_WIDTH]));
    check({tag, "_cyc"},  64'(bus.done_cycles), 64'(e[CNT_W-1:0]));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a start and return in the ARM cycle (one cycle after accept).
  task automatic do_start(input logic [EXCEPTION_NUM-1:0] cfg, input logic [CNT_W-1:0] lim);
    bit got_ack;
    got_ack = 0;
    bus.soc_start_req     = 1'b1;
    bus.soc_start_cfg     = cfg;
    bus.soc_timeout_limit = lim;
    for (int i = 0; i < 50 && !got_ack; i++) begin
      if (bus.soc_start_ack) got_ack = 1;
      step();
    end
    bus.soc_start_req = 1'b0;
    if (!got_ack) check("start_ack_wait", 64'd0, 64'd1);
  endtask

  // Complete the DONE handshake and confirm the return to IDLE.
  task automatic finish_done(input string tag);
    bus.done_rdy = 1'b1;
    step();
    bus.done_rdy = 1'b0;
    core_status  = ST_IDLE;
    check({tag, "_idle_vld"}, 64'(bus.done_vld), 64'd0);
    check({tag, "_idle_ack"}, 64'(bus.soc_start_ack), 64'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int p0;
    rst_n                 = 1'b0;
    bus.soc_start_req     = 1'b0;
    bus.soc_start_cfg     = '0;
    bus.soc_timeout_limit = '0;
    bus.soc_abort         = 1'b0;
    bus.done_rdy          = 1'b0;
    core_status           = ST_IDLE;
    core_exceptions       = '0;
    core_exceptions_pc    = '0;

    #3;
    check("rst_ack",   64'(bus.soc_start_ack), 64'd1);
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_pulse", 64'(sync_start_pulse), 64'd0);
    check("rst_vld",   64'(bus.done_vld), 64'd0);
    check("rst_cfg",   64'(sync_core_configuration), 64'd0);
    check("rst_cyc",   64'(bus.done_cycles), 64'd0);
    #9 rst_n = 1'b1;
    step();

    // Normal WFI: 10 running cycles, WFI on the 11th
    p0 = pulse_cnt;
    do_start(8'h05, 4'd0);
    check("wfi_pulse", 64'(sync_start_pulse), 64'd1);
    check("wfi_cfg",   64'(sync_core_configuration), 64'h5);
    check("wfi_ack",   64'(bus.soc_start_ack), 64'd0);
    core_status = ST_RUN;
    step();
    check("wfi_pulse_off", 64'(sync_start_pulse), 64'd0);
    repeat (10) step();
    core_status = ST_WFI;
    step();
    expect_done(DONE_WFI, '0, '0, 4'd11);
    check_done("wfi");
    check("wfi_one_pulse", 64'(pulse_cnt - p0), 64'd1);
    finish_done("wfi");

    // Exception after 3 running cycles
    do_start(8'h00, 4'd0);
    core_status = ST_RUN;
    repeat (4) step();
    core_status        = ST_IDLE;
    core_exceptions    = 8'h04;
    core_exceptions_pc = 32'h0000_0040;
    step();
    core_exceptions    = '0;
    core_exceptions_pc = '0;
    expect_done(DONE_EXC, 8'h04, 32'h40, 4'd4);
    check_done("exc");
    finish_done("exc");

    // Timeout at limit 4
    do_start(8'h00, 4'd4);
    core_status = ST_RUN;
    repeat (3) step();
    check("tmo_not_yet", 64'(bus.done_vld), 64'd0);
    step();
    step();
    expect_done(DONE_TMO, '0, '0, 4'd4);
    check_done("tmo");
    finish_done("tmo");

    // Status change on the timeout cycle wins
    do_start(8'h00, 4'd4);
    core_status = ST_RUN;
    repeat (4) step();
    core_status = ST_WFI;
    step();
    expect_done(DONE_WFI, '0, '0, 4'd4);
    check_done("tmo_vs_wfi");
    finish_done("tmo_vs_wfi");

    // Backpressure and a start queued during RUN
    do_start(8'h00, 4'd0);
    core_status = ST_RUN;
    step();
    bus.soc_start_req = 1'b1;
    bus.soc_start_cfg = 8'h09;
    check("bp_ack_run", 64'(bus.soc_start_ack), 64'd0);
    step();
    core_status = ST_WFI;
    step();
    expect_done(DONE_WFI, '0, '0, 4'd2);
    for (int i = 0; i < 5; i++) begin
      expect_done(DONE_WFI, '0, '0, 4'd2);
      check_done("bp_hold");
      check("bp_ack_done", 64'(bus.soc_start_ack), 64'd0);
      step();
    end
    check_done("bp_last");
    bus.done_rdy = 1'b1;
    step();
    bus.done_rdy = 1'b0;
    core_status  = ST_IDLE;
    check("bp_ack_idle", 64'(bus.soc_start_ack), 64'd1);
    step();
    bus.soc_start_req = 1'b0;
    check("bp_second_pulse", 64'(sync_start_pulse), 64'd1);
    check("bp_second_cfg",   64'(sync_core_configuration), 64'h9);
    // earliest completion: WFI in the first RUN cycle
    core_status = ST_WFI;
    step();
    step();
    expect_done(DONE_WFI, '0, '0, 4'd1);
    check_done("bp_fast");
    finish_done("bp_fast");

    // Abort in the 2nd RUN cycle
    do_start(8'h00, 4'd0);
    core_status = ST_RUN;
    step();
    step();
    bus.soc_abort = 1'b1;
    step();
    bus.soc_abort = 1'b0;
    expect_done(DONE_ABT, '0, '0, 4'd2);
    check_done("abt");
    finish_done("abt");

    // Abort in IDLE is ignored
    bus.soc_abort = 1'b1;
    repeat (3) step();
    bus.soc_abort = 1'b0;
    check("abt_idle_busy", 64'(busy), 64'd0);
    check("abt_idle_vld",  64'(bus.done_vld), 64'd0);

    // Timeout and abort together: timeout wins
    do_start(8'h00, 4'd2);
    core_status = ST_RUN;
    step();
    step();
    bus.soc_abort = 1'b1;
    step();
    bus.soc_abort = 1'b0;
    expect_done(DONE_TMO, '0, '0, 4'd2);
    check_done("tmo_vs_abt");
    finish_done("tmo_vs_abt");

    // Reset in the middle of a run
    do_start(8'h07, 4'd0);
    core_status = ST_RUN;
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    check("mrst_busy",  64'(busy), 64'd0);
    check("mrst_ack",   64'(bus.soc_start_ack), 64'd1);
    check("mrst_cfg",   64'(sync_core_configuration), 64'd0);
    check("mrst_code",  64'(bus.done_code), 64'd0);
    check("mrst_cyc",   64'(bus.done_cycles), 64'd0);
    check("mrst_state", 64'(state_dbg), 64'(S_IDLE));
    #2 rst_n = 1'b1;
    core_status = ST_IDLE;
    step();
    do_start(8'h03, 4'd0);
    check("mrst_restart_pulse", 64'(sync_start_pulse), 64'd1);
    check("mrst_restart_cfg",   64'(sync_core_configuration), 64'h3);
    core_status = ST_RUN;
    step();
    core_status = ST_WFI;
    step();
    expect_done(DONE_WFI, '0, '0, 4'd1);
    check_done("mrst_run");
    finish_done("mrst_run");

    // Counter saturation with the watchdog disabled
    do_start(8'h00, 4'd0);
    core_status = ST_RUN;
    repeat (21) step();
    check("sat_still_run", 64'(busy && !bus.done_vld), 64'd1);
    core_status = ST_WFI;
    step();
    expect_done(DONE_WFI, '0, '0, 4'hF);
    check_done("sat");
    finish_done("sat");

    // Largest limit: times out on the 15th RUN cycle
    do_start(8'h00, 4'hF);
    core_status = ST_RUN;
    repeat (16) step();
    expect_done(DONE_TMO, '0, '0, 4'hF);
    check_done("tmo_max");
    finish_done("tmo_max");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/core_run_ctrl.md
Name: core_run_ctrl

Overview:
- SoC-facing run-control sequencer for the core.
- Accepts a start request and configuration over a valid/ready handshake, then issues the one-cycle start pulse and configuration to the core status register.
- Monitors the core status, exception vector and exception PC until the run ends, and returns a completion record to the SoC over a second valid/ready handshake.
- Provides a run-cycle counter with an optional watchdog timeout and a software abort.

Parameters:
- CNT_W, 32, width of the run-cycle counter and of the timeout limit.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- soc_start_req  in  1  start request valid
- soc_start_ack  out  1  start request ready; high only in IDLE
- soc_start_cfg  in  `EXCEPTION_NUM  configuration word, sampled on accept
- soc_timeout_limit  in  CNT_W  watchdog limit in RUN cycles; 0 = disabled; sampled on accept
- soc_abort  in  1  software abort, honoured only in RUN
- sync_start_pulse  out  1  one-cycle start strobe to the core status register
- sync_core_configuration  out  `EXCEPTION_NUM  latched configuration
- core_status  in  2  00 idle/exception, 01 running, 10 WFI halt, 11 illegal
- core_exceptions  in  `EXCEPTION_NUM  exception vector from the status register
- core_exceptions_pc  in  `PC_WIDTH  exception PC from the status register
- done_vld  out  1  completion record valid
- done_rdy  in  1  completion record accepted by the SoC
- done_code  out  2  00 WFI, 01 EXCEPTION, 10 TIMEOUT, 11 ABORT
- done_exceptions  out  `EXCEPTION_NUM  captured exception vector
- done_pc  out  `PC_WIDTH  captured exception PC
- done_cycles  out  CNT_W  RUN cycles, including the ending cycle
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset state: IDLE.
- Reset values: every output register is 0. soc_start_ack is 1 (combinational from IDLE). busy is 0.
- States:
  - IDLE: start transfer occurs when soc_start_req and soc_start_ack are both high at a clock edge. On that edge: latch cfg into sync_core_configuration; latch limit; clear run_cnt; go to ARM.
  - ARM: exactly one cycle. sync_start_pulse is high for this cycle only. Then go to RUN.
  - RUN (first cycle: core_status already reads 01): each cycle, exit conditions are checked in priority order. If none applies, run_cnt increments, saturating at all-ones.
    1. core_status != 01 → capture and go to DONE. Code is WFI if status is 10, otherwise EXCEPTION (00 or 11).
    2. Timeout: limit != 0 and run_cnt == limit-1 → code TIMEOUT.
    3. soc_abort → code ABORT.
  - DONE: done_vld is held high with all done_* fields stable. On done_vld & done_rdy, go to IDLE. done_* fields keep their values until the next capture.
- Capture on any RUN exit, registered at the exit edge:
  - done_exceptions ← core_exceptions
  - done_pc ← core_exceptions_pc
  - done_cycles ← run_cnt+1, saturating
- Capture values by code:
  - WFI: exceptions are 0.
  - TIMEOUT / ABORT: the core has not been stopped. Exceptions and PC are captured as-is, normally 0. The SoC restarts the core via a new start, which clears the status register.
- Latency: accept edge N → pulse during cycle N+1 → first RUN cycle N+2 → earliest done_vld in cycle N+3.
- Simultaneous events:
  - Status change in the same cycle as timeout or abort: the status change wins.
  - Timeout in the same cycle as abort: timeout wins.
  - soc_abort outside RUN is ignored.
  - soc_start_req while busy: it stalls (ack low) and is not lost.
- done_rdy while done_vld is low: ignored.
- Back-to-back: a start can be accepted in the cycle after the DONE handshake (IDLE).
- Reset mid-run: immediate return to IDLE with all outputs 0, including done_vld and sync_start_pulse.
- run_cnt saturation: at all-ones with limit 0, RUN continues and done_cycles reports all-ones.

Decomposition:
- Shared defines package:
  - `EXCEPTION_NUM and `PC_WIDTH (existing).
  - New done-code constants: DONE_WFI=2'b00, DONE_EXC=2'b01, DONE_TMO=2'b10, DONE_ABT=2'b11.
  - Core-status encodings: ST_IDLE=2'b00, ST_RUN=2'b01, ST_WFI=2'b10.
  - FSM state encodings.
- One sub-module: run_cycle_counter, a saturating CNT_W counter with clear, enable and a "==limit-1" compare output.

Test Plan:
- Normal WFI:
  - Stimulus: cfg=0x5, limit=0; model drives status 01 for 10 RUN cycles, then 10.
  - Required: single sync_start_pulse with sync_core_configuration=0x5; done_code=00, done_cycles=11, done_exceptions=0.
- Exception:
  - Stimulus: status 01 for 3 cycles, then 00 with exceptions=0x4, pc=0x0000_0040.
  - Required: done_code=01, done_exceptions=0x4, done_pc=0x40, done_cycles=4.
- Timeout vs completion:
  - Stimulus: limit=4 with status held at 01.
  - Required: done_code=10, done_cycles=4 on the 4th RUN cycle.
  - Repeat with status going to 10 on that same 4th cycle. Required: done_code=00.
- Handshake / backpressure:
  - Stimulus: done_rdy low for 5 cycles; second soc_start_req asserted during RUN.
  - Required: done_vld and fields stable throughout; soc_start_ack stays 0 until IDLE; second start accepted the cycle after the done handshake.
- Abort and ignored abort:
  - Stimulus: soc_abort in the 2nd RUN cycle.
  - Required: done_code=11, done_cycles=2.
  - Stimulus: soc_abort while in IDLE. Required: no effect.
- Reset mid-run:
  - Stimulus: rst_n low during RUN.
  - Required: asynchronously IDLE, all outputs 0, ack=1; a new start works normally afterwards.
